fir_tdm_sequencer: RTL

- Time-division-multiplexed FIR controller that owns one fir_dsp_core instance and sequences NTAPS multiply-accumulates per input sample through it.
- Holds the sample delay line and a double-buffered (shadow/active) coefficient bank.
- Accumulates the returned DSP products into a 48-bit result presented on a valid/ready output.
- Sits between a sample stream source and a decimating/low-rate consumer.

---
 rtl/fir_tdm_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fir_tdm_sequencer.sv
// Time-division-multiplexed FIR controller: one external DSP slice is fed one tap per
// cycle, products are tagged through a latency-matched pipe and accumulated to 48 bits.
//
// state | meaning
// IDLE  | waiting for a sample; shadow->active commit happens here
// ISSUE | one tap per cycle driven to the DSP slice
// DRAIN | waiting for the last tagged product to return
// HOLD  | result presented until the consumer takes it
module fir_tdm_sequencer #(
  parameter int NTAPS       = 16,
  parameter int DATA_W      = 16,
  parameter int DSP_LATENCY = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [DATA_W-1:0]         s_tdata_i,
  input  logic                      s_tvalid_i,
  output logic                      s_tready_o,
  input  logic                      coef_wr_i,
  input  logic [$clog2(NTAPS)-1:0]  coef_addr_i,
  input  logic [17:0]               coef_data_i,
  input  logic                      coef_commit_i,
  output logic                      commit_pending_o,
  output logic [25:0]               dsp_a_o,
  output logic [17:0]               dsp_b_o,
  output logic [47:0]               dsp_c_o,
  input  logic [47:0]               dsp_p_i,
  output logic [47:0]               m_tdata_o,
  output logic                      m_tvalid_o,
  input  logic                      m_tready_i,
  output logic                      busy_o
);
  localparam int AW = $clog2(NTAPS);
  localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_e;

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic              s_tready_q;
  logic              m_tvalid_q;
  logic [47:0]       m_tdata_q;
  logic [47:0]       acc_q;
  logic [47:0]       acc_sum;
  logic [25:0]       dsp_a_q;
  logic [17:0]       dsp_b_q;
  logic [DATA_W-1:0] delay_q  [NTAPS];
  logic [17:0]       shadow_q [NTAPS];
  logic [17:0]       active_q [NTAPS];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [AW-1:0]     k_q;
  logic [DSP_LATENCY-1:0] tag_v_q, tag_f_q, tag_l_q;
  logic              accept;
  logic              do_commit;
  logic              addr_ok;
  logic              tag_v, tag_f, tag_l;

  // Out-of-range tap addresses only exist when NTAPS is not a power of two.
  if ((1 << AW) == NTAPS) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_chk
    assign addr_ok = ({1'b0, coef_addr_i} < (AW+1)'(NTAPS));
  end

  assign accept    = s_tvalid_i & s_tready_q;
  assign do_commit = (state_q == IDLE) & pending_q;
  assign tag_v     = tag_v_q[DSP_LATENCY-1];
  assign tag_f     = tag_f_q[DSP_LATENCY-1];
  assign tag_l     = tag_l_q[DSP_LATENCY-1];
  assign acc_sum   = tag_f ? dsp_p_i : acc_q + dsp_p_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (k_q == LAST_TAP) state_d = DRAIN;
      DRAIN:   if (tag_v && tag_l) state_d = HOLD;
      HOLD:    if (m_tready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pending_d = pending_q;
    if (do_commit)          pending_d = 1'b0;
    else if (coef_commit_i) pending_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      acc_q      <= '0;
      dsp_a_q    <= '0;
      dsp_b_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      k_q        <= '0;
      tag_v_q    <= '0;
      tag_f_q    <= '0;
      tag_l_q    <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        delay_q[i]  <= '0;
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      // Ready is held low for the IDLE cycle in which a pending commit is applied.
      s_tready_q <= (state_d == IDLE) && !pending_d;

      if (coef_wr_i && addr_ok) shadow_q[coef_addr_i] <= coef_data_i;

      for (int i = DSP_LATENCY - 1; i > 0; i--) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_f_q[i] <= tag_f_q[i-1];
        tag_l_q[i] <= tag_l_q[i-1];
      end
      tag_v_q[0] <= (state_q == ISSUE);
      tag_f_q[0] <= (state_q == ISSUE) && (k_q == '0);
      tag_l_q[0] <= (state_q == ISSUE) && (k_q == LAST_TAP);

      if (tag_v) acc_q <= acc_sum;

      case (state_q)
        IDLE: begin
          if (do_commit) begin
            for (int i = 0; i < NTAPS; i++) active_q[i] <= shadow_q[i];
          end else if (accept) begin
            delay_q[wptr_q] <= s_tdata_i;
            wptr_q  <= (wptr_q == LAST_TAP) ? '0 : wptr_q + 1'b1;
            rptr_q  <= (wptr_q == '0) ? LAST_TAP : wptr_q - 1'b1;
            k_q     <= '0;
            dsp_a_q <= 26'($signed(s_tdata_i));
            dsp_b_q <= active_q[0];
          end
        end
        ISSUE: begin
          if (k_q == LAST_TAP) begin
            dsp_a_q <= '0;
            dsp_b_q <= '0;
          end else begin
            // Operands for tap k+1 walk the delay line backwards from the newest sample.
            dsp_a_q <= 26'($signed(delay_q[rptr_q]));
            dsp_b_q <= active_q[k_q + 1'b1];
            rptr_q  <= (rptr_q == '0) ? LAST_TAP : rptr_q - 1'b1;
            k_q     <= k_q + 1'b1;
          end
        end
        DRAIN: begin
          if (tag_v && tag_l) begin
            m_tdata_q  <= acc_sum;
            m_tvalid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (m_tready_i) m_tvalid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign s_tready_o       = s_tready_q;
  assign commit_pending_o = pending_q;
  assign dsp_a_o          = dsp_a_q;
  assign dsp_b_o          = dsp_b_q;
  assign dsp_c_o          = '0;
  assign m_tdata_o        = m_tdata_q;
  assign m_tvalid_o       = m_tvalid_q;
  assign busy_o           = (state_q != IDLE);

endmodule
